mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 64-bit memory port between two requesters: A = instruction fetch, B = data access.
//  - Sequences each access: grant -> hold -> complete/timeout.
//  - Latches the winner's address and drives the select of the Mux_2x1 that steers the port.
//  - Round-robin arbitration; an optional fixed-priority mode is available.
//  - Sits between the IF/MEM stages and the shared memory interface.
// PARAMETERS
//  ADDR_W       64   address width (Mux_2x1 data width)
//  TIMEOUT_CYC  255  max cycles in BUSY without mem_ready before abort (must be >=1)
//  CNT_W        8    width of wait counter (must hold TIMEOUT_CYC)
//  FIXED_PRIO   0    0 = round-robin; 1 = B always wins on simultaneous requests
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  req_a        in   1       requester A wants the port; held until done_a/timeout_err
//  addr_a       in   ADDR_W  requester A address; sampled on grant
//  req_b        in   1       requester B wants the port; held until done_b/timeout_err
//  addr_b       in   ADDR_W  requester B address; sampled on grant
//  mem_ready    in   1       memory completes current access this cycle
//  mem_req      out  1       access in progress to memory
//  mem_addr     out  ADDR_W  registered address of granted requester
//  sel_bit      out  1       Mux_2x1 select: 0 = A owns port, 1 = B owns port
//  gnt_a        out  1       A currently owns port (high for whole access)
//  gnt_b        out  1       B currently owns port
//  done_a       out  1       1-cycle pulse: A access completed
//  done_b       out  1       1-cycle pulse: B access completed
//  timeout_err  out  1       1-cycle pulse: access aborted on timeout
// BEHAVIOUR
//  - Reset (sync, reset=1 at posedge):
//    - state=IDLE; all outputs 0; mem_addr=0; wait_cnt=0.
//    - last_gnt=B, so A wins the first tie.
//    - Reset mid-access aborts it: no done pulse, no timeout_err.
//  - States: IDLE, BUSY_A, BUSY_B. All outputs registered.
//  - IDLE:
//    - No request: stay.
//    - Exactly one request: go to that requester's BUSY state.
//    - Both requesting:
//      - FIXED_PRIO=1: B wins.
//      - FIXED_PRIO=0: the requester not in last_gnt wins.
//    - On entry to BUSY_x:
//      - gnt_x=1 and mem_req=1.
//      - sel_bit = (x==B).
//      - mem_addr <= addr_x; last_gnt <= x; wait_cnt <= 0.
//    - mem_ready in IDLE is ignored.
//  - BUSY_x:
//    - mem_addr, sel_bit, gnt_x and mem_req are stable; addr_x changes and req_x deassertion
//      are ignored until the access ends.
//    - mem_ready=1: next cycle done_x=1 (one cycle), gnt_x=0, mem_req=0, state=IDLE.
//    - Else wait_cnt++. When wait_cnt==TIMEOUT_CYC-1 with no mem_ready:
//      - next cycle timeout_err=1 (one cycle), no done_x, state=IDLE.
//    - mem_ready on the timeout cycle wins: done_x, no error.
//  - Latency:
//    - req sampled at edge N -> gnt/mem_req high after edge N.
//    - mem_ready at edge M -> done pulse after edge M.
//    - Earliest next grant is after edge M+1: one bubble cycle between accesses.
//  - Invariants:
//    - gnt_a & gnt_b never both high.
//    - mem_req == gnt_a | gnt_b.
//    - done_a, done_b and timeout_err are mutually exclusive.
//    - sel_bit holds its last value in IDLE.
// TESTING
//  1. Reset then req_a=1, addr_a=0x1000, mem_ready 2 cycles later
//     -> gnt_a/mem_req 1 cycle after req; mem_addr=0x1000, sel_bit=0; done_a 1-cycle pulse.
//  2. req_a=req_b=1 held, RR mode, mem_ready after each grant
//     -> grants alternate A,B,A,B with one idle bubble between; sel_bit 0,1,0,1.
//  3. FIXED_PRIO=1, both held
//     -> B granted every time; A starves; sel_bit=1 each access.
//  4. req_b, addr_b=0xBEEF; change addr_b to 0x0 and drop req_b mid-access
//     -> mem_addr stays 0xBEEF; done_b on mem_ready.
//  5. TIMEOUT_CYC=4, req_a, mem_ready never
//     -> timeout_err pulse 4 cycles after grant; no done_a; back to IDLE.
//  6. reset=1 during BUSY_B -> next cycle all outputs 0, no done_b; the next tie is granted to A.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and grant signals shared by the arbiter and its environment.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic              mem_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              sel_bit;
    logic              gnt_a;
    logic              gnt_b;
    logic              done_a;
    logic              done_b;
    logic              timeout_err;

    modport slave (
        input  req_a, addr_a, req_b, addr_b, mem_ready,
        output mem_req, mem_addr, sel_bit, gnt_a, gnt_b, done_a, done_b, timeout_err
    );

    modport master (
        output req_a, addr_a, req_b, addr_b, mem_ready,
        input  mem_req, mem_addr, sel_bit, gnt_a, gnt_b, done_a, done_b, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared memory port: A is instruction fetch, B is data access.
// Every output is registered. Each access runs grant -> hold -> done or timeout.
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic              last_gnt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              pick_b;
    logic [ADDR_W-1:0] next_addr;

    // B wins when it is the only requester, or on a tie when it has priority or its turn has come.
    always_comb begin
        pick_b    = 1'b0;
        next_addr = bus.addr_a;
        if (bus.req_b && (!bus.req_a || FIXED_PRIO || !last_gnt)) begin
            pick_b = 1'b1;
        end
        if (pick_b) begin
            next_addr = bus.addr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            last_gnt        <= 1'b1;
            wait_cnt        <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.sel_bit     <= 1'b0;
            bus.gnt_a       <= 1'b0;
            bus.gnt_b       <= 1'b0;
            bus.done_a      <= 1'b0;
            bus.done_b      <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.done_a      <= 1'b0;
            bus.done_b      <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        state        <= pick_b ? BUSY_B : BUSY_A;
                        last_gnt     <= pick_b;
                        wait_cnt     <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= next_addr;
                        bus.sel_bit  <= pick_b;
                        bus.gnt_a    <= !pick_b;
                        bus.gnt_b    <= pick_b;
                    end
                end
                BUSY_A, BUSY_B: begin
                    // A ready on the final wait cycle still completes the access normally.
                    if (bus.mem_ready) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.gnt_a   <= 1'b0;
                        bus.gnt_b   <= 1'b0;
                        bus.done_a  <= (state == BUSY_A);
                        bus.done_b  <= (state == BUSY_B);
                    end else if (wait_cnt == LAST_CNT) begin
                        state           <= IDLE;
                        bus.mem_req     <= 1'b0;
                        bus.gnt_a       <= 1'b0;
                        bus.gnt_b       <= 1'b0;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin instance with a short timeout and a fixed-priority instance share stimulus.
// Status vectors are {mem_req, sel_bit, gnt_a, gnt_b, done_a, done_b, timeout_err}.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0;
    logic [63:0] addr_a = '0;
    logic        req_b = 1'b0;
    logic [63:0] addr_b = '0;
    logic        mem_ready = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  st0;
    logic [6:0]  st1;

    localparam logic [6:0] S_IDLE_A = 7'b0000000;
    localparam logic [6:0] S_IDLE_B = 7'b0100000;
    localparam logic [6:0] S_GNT_A  = 7'b1010000;
    localparam logic [6:0] S_GNT_B  = 7'b1101000;
    localparam logic [6:0] S_DONE_A = 7'b0000100;
    localparam logic [6:0] S_DONE_B = 7'b0100010;
    localparam logic [6:0] S_TMO_A  = 7'b0000001;

    mem_port_arbiter_if #(.ADDR_W(64)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(64)) bus1 ();

    assign bus0.req_a = req_a;
    assign bus0.addr_a = addr_a;
    assign bus0.req_b = req_b;
    assign bus0.addr_b = addr_b;
    assign bus0.mem_ready = mem_ready;
    assign bus1.req_a = req_a;
    assign bus1.addr_a = addr_a;
    assign bus1.req_b = req_b;
    assign bus1.addr_b = addr_b;
    assign bus1.mem_ready = mem_ready;

    assign st0 = {bus0.mem_req, bus0.sel_bit, bus0.gnt_a, bus0.gnt_b,
                  bus0.done_a, bus0.done_b, bus0.timeout_err};
    assign st1 = {bus1.mem_req, bus1.sel_bit, bus1.gnt_a, bus1.gnt_b,
                  bus1.done_a, bus1.done_b, bus1.timeout_err};

    mem_port_arbiter #(.ADDR_W(64), .TIMEOUT_CYC(4), .CNT_W(8), .FIXED_PRIO(1'b0)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    mem_port_arbiter #(.ADDR_W(64), .TIMEOUT_CYC(255), .CNT_W(8), .FIXED_PRIO(1'b1)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive inputs after a falling edge, then advance to the next falling edge to sample.
    task automatic applyStimulus(input logic ra, input logic [63:0] aa, input logic rb,
                                 input logic [63:0] ab, input logic rdy);
        req_a = ra;
        addr_a = aa;
        req_b = rb;
        addr_b = ab;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_status", {57'd0, st0}, {57'd0, S_IDLE_A});
        checkOutput("reset_addr", bus0.mem_addr, 64'h0);
        reset = 1'b0;

        applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_grant", {57'd0, st0}, {57'd0, S_GNT_A});
        checkOutput("t1_addr", bus0.mem_addr, 64'h1000);
        applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_hold", {57'd0, st0}, {57'd0, S_GNT_A});
        applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b1);
        checkOutput("t1_done", {57'd0, st0}, {57'd0, S_DONE_A});
        applyStimulus(1'b0, 64'h1000, 1'b0, 64'h0, 1'b0);
        checkOutput("t1_idle", {57'd0, st0}, {57'd0, S_IDLE_A});

        applyStimulus(1'b0, 64'h0, 1'b1, 64'hBEEF, 1'b0);
        checkOutput("t4_grant", {57'd0, st0}, {57'd0, S_GNT_B});
        checkOutput("t4_addr", bus0.mem_addr, 64'hBEEF);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("t4_hold", {57'd0, st0}, {57'd0, S_GNT_B});
        checkOutput("t4_addr_hold", bus0.mem_addr, 64'hBEEF);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        checkOutput("t4_done", {57'd0, st0}, {57'd0, S_DONE_B});
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("t4_idle_sel", {57'd0, st0}, {57'd0, S_IDLE_B});
        checkOutput("t4_addr_idle", bus0.mem_addr, 64'hBEEF);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 64'hA0, 1'b1, 64'hB0, 1'b0);
            checkOutput($sformatf("t2_grant_%0d", k), {57'd0, st0},
                        {57'd0, (k % 2 == 1) ? S_GNT_B : S_GNT_A});
            checkOutput($sformatf("t2_addr_%0d", k), bus0.mem_addr,
                        (k % 2 == 1) ? 64'hB0 : 64'hA0);
            checkOutput($sformatf("t3_grant_%0d", k), {57'd0, st1}, {57'd0, S_GNT_B});
            checkOutput($sformatf("t3_addr_%0d", k), bus1.mem_addr, 64'hB0);
            applyStimulus(1'b1, 64'hA0, 1'b1, 64'hB0, 1'b1);
            checkOutput($sformatf("t2_done_%0d", k), {57'd0, st0},
                        {57'd0, (k % 2 == 1) ? S_DONE_B : S_DONE_A});
            checkOutput($sformatf("t3_done_%0d", k), {57'd0, st1}, {57'd0, S_DONE_B});
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("t2_idle", {57'd0, st0}, {57'd0, S_IDLE_B});

        applyStimulus(1'b1, 64'h55, 1'b0, 64'h0, 1'b0);
        checkOutput("t5_grant", {57'd0, st0}, {57'd0, S_GNT_A});
        for (int w = 1; w <= 3; w++) begin
            applyStimulus(1'b1, 64'h55, 1'b0, 64'h0, 1'b0);
            checkOutput($sformatf("t5_wait_%0d", w), {57'd0, st0}, {57'd0, S_GNT_A});
        end
        applyStimulus(1'b1, 64'h55, 1'b0, 64'h0, 1'b0);
        checkOutput("t5_timeout", {57'd0, st0}, {57'd0, S_TMO_A});
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        checkOutput("t5_idle", {57'd0, st0}, {57'd0, S_IDLE_A});

        reset = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h77, 1'b0);
        checkOutput("t6_grant_b", {57'd0, st0}, {57'd0, S_GNT_B});
        reset = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h77, 1'b1);
        checkOutput("t6_reset_status", {57'd0, st0}, {57'd0, S_IDLE_A});
        checkOutput("t6_reset_addr", bus0.mem_addr, 64'h0);
        reset = 1'b0;
        applyStimulus(1'b1, 64'h99, 1'b1, 64'h77, 1'b0);
        checkOutput("t6_tie_rr", {57'd0, st0}, {57'd0, S_GNT_A});
        checkOutput("t6_tie_addr", bus0.mem_addr, 64'h99);
        checkOutput("t6_tie_fp", {57'd0, st1}, {57'd0, S_GNT_B});
        applyStimulus(1'b1, 64'h99, 1'b1, 64'h77, 1'b1);
        checkOutput("t6_done_a", {57'd0, st0}, {57'd0, S_DONE_A});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
